// File: rtl/turn_pkg.sv
// Shared types and decode helpers for the tail-light turn-signal front end.
package turn_pkg;

   typedef enum logic [1:0] {Z = 2'b00, R = 2'b01, L = 2'b10, H = 2'b11} mode_t;

   typedef enum logic [2:0] {IDLE, LEFT, RIGHT, HAZARD, GAP, LOCK} ctrl_state_t;

   typedef enum logic [1:0] {NONE, REQ_L, REQ_R, REQ_H} req_t;

   // Hazard wins outright; simultaneous left and right cancel each other.
   function automatic req_t resolve_req(input logic db_l, input logic db_r, input logic db_h);
      if (db_h)              return REQ_H;
      else if (db_l && db_r) return NONE;
      else if (db_l)         return REQ_L;
      else if (db_r)         return REQ_R;
      else                   return NONE;
   endfunction

   function automatic ctrl_state_t req_to_state(input req_t q);
      case (q)
         REQ_L:   return LEFT;
         REQ_R:   return RIGHT;
         REQ_H:   return HAZARD;
         default: return IDLE;
      endcase
   endfunction

   function automatic req_t state_to_req(input ctrl_state_t s);
      case (s)
         LEFT:    return REQ_L;
         RIGHT:   return REQ_R;
         HAZARD:  return REQ_H;
         default: return NONE;
      endcase
   endfunction

   function automatic mode_t state_to_mode(input ctrl_state_t s);
      case (s)
         LEFT:    return L;
         RIGHT:   return R;
         HAZARD:  return H;
         default: return Z;
      endcase
   endfunction

endpackage

// File: rtl/switch_debounce.sv
// Two-flop synchronizer followed by a consecutive-cycle debounce for one switch.
module switch_debounce #(
   parameter int unsigned DEBOUNCE_CYC = 4
) (
   input  logic clk_out,
   input  logic rst,
   input  logic raw,
   output logic db
);

   localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYC) + 1;

   logic             sync_1;
   logic             sync_2;
   logic [CNT_W-1:0] cnt;

   // Any return of the synchronized level to db restarts the count.
   always_ff @(posedge clk_out or negedge rst) begin
      if (!rst) begin
         sync_1 <= 1'b0;
         sync_2 <= 1'b0;
         db     <= 1'b0;
         cnt    <= '0;
      end else begin
         sync_1 <= raw;
         sync_2 <= sync_1;
         if (sync_2 == db) begin
            cnt <= '0;
         end else if (cnt == CNT_W'(DEBOUNCE_CYC - 1)) begin
            db  <= sync_2;
            cnt <= '0;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/turn_signal_input_ctrl.sv
// Conditions raw left/right/hazard switches into clean, mutually exclusive
// l/r/h commands with an idle gap between commands and turn-signal auto-cancel.
module turn_signal_input_ctrl
   import turn_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYC = 4,
   parameter int unsigned TIMEOUT_CYC  = 64
) (
   input  logic       clk_out,
   input  logic       rst,
   input  logic       l_raw,
   input  logic       r_raw,
   input  logic       h_raw,
   output logic       l,
   output logic       r,
   output logic       h,
   output logic [1:0] mode,
   output logic       timeout_flag
);

   localparam int unsigned DWELL_W = $clog2(TIMEOUT_CYC) + 1;
   localparam bit          TO_EN   = (TIMEOUT_CYC != 0);

   logic               db_l;
   logic               db_r;
   logic               db_h;
   req_t               req_c;
   ctrl_state_t        state;
   ctrl_state_t        state_nxt;
   req_t               lock_dir;
   logic [DWELL_W-1:0] dwell;
   logic               timed_out;

   switch_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_l (
      .clk_out (clk_out),
      .rst     (rst),
      .raw     (l_raw),
      .db      (db_l)
   );

   switch_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_r (
      .clk_out (clk_out),
      .rst     (rst),
      .raw     (r_raw),
      .db      (db_r)
   );

   switch_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_h (
      .clk_out (clk_out),
      .rst     (rst),
      .raw     (h_raw),
      .db      (db_h)
   );

   always_comb req_c = resolve_req(db_l, db_r, db_h);

   // Dwell reaches TIMEOUT_CYC-1 on the last cycle a turn command may stay up.
   always_comb timed_out = TO_EN && (dwell == DWELL_W'(TIMEOUT_CYC - 1));

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE, GAP: state_nxt = req_to_state(req_c);
         LEFT, RIGHT, HAZARD: begin
            if (req_c == NONE)                     state_nxt = IDLE;
            else if (req_c != state_to_req(state)) state_nxt = GAP;
            else if (state != HAZARD && timed_out) state_nxt = LOCK;
         end
         LOCK:    if (req_c != lock_dir) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Outputs are decoded from the next state so they register alongside it.
   always_ff @(posedge clk_out or negedge rst) begin
      if (!rst) begin
         state        <= IDLE;
         lock_dir     <= NONE;
         dwell        <= '0;
         l            <= 1'b0;
         r            <= 1'b0;
         h            <= 1'b0;
         mode         <= 2'b00;
         timeout_flag <= 1'b0;
      end else begin
         state        <= state_nxt;
         timeout_flag <= (state_nxt == LOCK) && (state != LOCK);
         if (state_nxt == LOCK && state != LOCK)
            lock_dir <= state_to_req(state);
         if (state_nxt != state)
            dwell <= '0;
         else if (dwell != '1)
            dwell <= dwell + 1'b1;
         l    <= (state_nxt == LEFT);
         r    <= (state_nxt == RIGHT);
         h    <= (state_nxt == HAZARD);
         mode <= 2'(state_to_mode(state_nxt));
      end
   end

endmodule

// File: tb/tb_turn_signal_input_ctrl.sv
// Scoreboard bench: each stimulus step queues the output word expected at a
// given future clk_out edge; a negedge monitor pops and compares them.
module tb_turn_signal_input_ctrl;

   // Output word {l, r, h, mode[1:0], timeout_flag}
   localparam logic [5:0] O_IDLE = 6'b000_00_0;
   localparam logic [5:0] O_L    = 6'b100_10_0;
   localparam logic [5:0] O_R    = 6'b010_01_0;
   localparam logic [5:0] O_H    = 6'b001_11_0;
   localparam logic [5:0] O_TO   = 6'b000_00_1;

   typedef struct {
      int         at;
      string      tag;
      logic [5:0] val;
   } exp_t;

   logic       clk_out = 1'b0;
   logic       rst;
   logic       l_raw;
   logic       r_raw;
   logic       h_raw;
   logic       l;
   logic       r;
   logic       h;
   logic [1:0] mode;
   logic       timeout_flag;

   int   cyc = 0;
   int   n_checks = 0;
   int   n_fails = 0;
   exp_t sb[$];

   turn_signal_input_ctrl dut (
      .clk_out      (clk_out),
      .rst          (rst),
      .l_raw        (l_raw),
      .r_raw        (r_raw),
      .h_raw        (h_raw),
      .l            (l),
      .r            (r),
      .h            (h),
      .mode         (mode),
      .timeout_flag (timeout_flag)
   );

   always #5 clk_out = ~clk_out;

   always @(posedge clk_out) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fails++;
         $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
      end
   endtask

   // Queue the expected output word for offsets lo..hi edges from now.
   task automatic expect_span(input int lo, input int hi, input string tag, input logic [5:0] val);
      for (int o = lo; o <= hi; o++)
         sb.push_back('{at: cyc + o, tag: $sformatf("%s+%0d", tag, o), val: val});
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk_out);
   endtask

   always @(negedge clk_out) begin
      for (int i = sb.size() - 1; i >= 0; i--) begin
         if (sb[i].at == cyc) begin
            check(sb[i].tag, 32'({l, r, h, mode, timeout_flag}), 32'(sb[i].val));
            sb.delete(i);
         end
      end
   end

   initial begin
      rst   = 1'b0;
      l_raw = 1'b1;
      r_raw = 1'b1;
      h_raw = 1'b1;

      // Reset held with every switch on, then full latency after release
      step(1);
      expect_span(1, 4, "rst_hold", O_IDLE);
      step(4);
      rst = 1'b1;
      expect_span(1, 6, "rst_rel_quiet", O_IDLE);
      expect_span(7, 8, "rst_rel_haz", O_H);
      step(8);
      l_raw = 1'b0;
      r_raw = 1'b0;
      h_raw = 1'b0;
      expect_span(1, 6, "all_off_hold", O_H);
      expect_span(7, 8, "all_off", O_IDLE);
      step(10);

      // Clean left press, release, then a bouncing left switch
      l_raw = 1'b1;
      expect_span(1, 6, "left_lat", O_IDLE);
      expect_span(7, 10, "left_on", O_L);
      step(10);
      l_raw = 1'b0;
      expect_span(1, 6, "left_rel_hold", O_L);
      expect_span(7, 9, "left_rel", O_IDLE);
      step(12);
      expect_span(1, 18, "bounce", O_IDLE);
      for (int k = 0; k < 3; k++) begin
         l_raw = 1'b1;
         step(2);
         l_raw = 1'b0;
         step(2);
      end
      step(10);

      // Hazard preempts left through a gap, and back again
      l_raw = 1'b1;
      expect_span(1, 6, "pre_lat", O_IDLE);
      expect_span(7, 10, "pre_left", O_L);
      step(10);
      h_raw = 1'b1;
      expect_span(1, 6, "haz_lat", O_L);
      expect_span(7, 7, "gap_to_haz", O_IDLE);
      expect_span(8, 10, "haz_on", O_H);
      step(12);
      h_raw = 1'b0;
      expect_span(1, 6, "haz_drop_hold", O_H);
      expect_span(7, 7, "gap_to_left", O_IDLE);
      expect_span(8, 10, "left_back", O_L);
      step(10);
      l_raw = 1'b0;
      expect_span(1, 6, "pre_rel_hold", O_L);
      expect_span(7, 8, "pre_rel", O_IDLE);
      step(10);

      // Left and right together cancel; releasing right yields left
      l_raw = 1'b1;
      r_raw = 1'b1;
      expect_span(1, 14, "conflict", O_IDLE);
      step(14);
      r_raw = 1'b0;
      expect_span(1, 6, "conf_rel_lat", O_IDLE);
      expect_span(7, 9, "conf_left", O_L);
      step(10);
      l_raw = 1'b0;
      expect_span(1, 6, "conf_off_hold", O_L);
      expect_span(7, 8, "conf_off", O_IDLE);
      step(10);

      // Right held 100 cycles: 64 cycles on, one flag pulse, then locked out
      r_raw = 1'b1;
      expect_span(1, 6, "to_lat", O_IDLE);
      expect_span(7, 70, "to_right", O_R);
      expect_span(71, 71, "to_flag", O_TO);
      expect_span(72, 99, "to_locked", O_IDLE);
      step(100);
      r_raw = 1'b0;
      expect_span(1, 10, "to_release", O_IDLE);
      step(10);
      r_raw = 1'b1;
      expect_span(1, 6, "repress_lat", O_IDLE);
      expect_span(7, 10, "repress_on", O_R);
      step(10);
      r_raw = 1'b0;
      expect_span(1, 6, "repress_rel_hold", O_R);
      expect_span(7, 8, "repress_rel", O_IDLE);
      step(10);

      // Reset asserted mid-hazard drops outputs at once
      h_raw = 1'b1;
      expect_span(1, 6, "rh_lat", O_IDLE);
      expect_span(7, 9, "rh_haz", O_H);
      step(10);
      #2 rst = 1'b0;
      #1 check("rst_async", 32'({l, r, h, mode, timeout_flag}), 32'(O_IDLE));
      expect_span(1, 3, "rh_in_rst", O_IDLE);
      step(3);
      rst = 1'b1;
      expect_span(1, 6, "rh_rel_lat", O_IDLE);
      expect_span(7, 9, "rh_haz_again", O_H);
      step(10);
      h_raw = 1'b0;
      expect_span(1, 6, "rh_off_hold", O_H);
      expect_span(7, 8, "rh_off", O_IDLE);
      step(12);

      check("sb_drain", 32'(sb.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
      $finish;
   end

endmodule

// File: doc/turn_signal_input_ctrl.md
Name: turn_signal_input_ctrl

Overview:
Front-end conditioner for the tail-light sequencer. Takes raw, bouncy, asynchronous left/right/hazard switch levels. Synchronizes and debounces each one, resolves conflicts, and drives the sequencer's l/r/h command inputs. Also enforces a clean idle gap between commands and auto-cancels turn signals left on too long. Runs entirely on the divided clock clk_out.

Parameters:
DEBOUNCE_CYC, 4, consecutive clk_out cycles a synchronized input must differ from its debounced value before the debounced value updates (>=1).
TIMEOUT_CYC, 64, clk_out cycles a LEFT/RIGHT command may stay active before auto-cancel; 0 disables timeout.

Ports:
clk_out  input  1  divided system clock; all state updates on posedge.
rst  input  1  reset; asynchronous, active-low.
l_raw  input  1  raw left switch, asynchronous.
r_raw  input  1  raw right switch, asynchronous.
h_raw  input  1  raw hazard switch, asynchronous.
l  output  1  clean left command to the sequencer.
r  output  1  clean right command to the sequencer.
h  output  1  clean hazard command to the sequencer.
mode  output  2  current command: 00 none, 01 right, 10 left, 11 hazard.
timeout_flag  output  1  one-cycle pulse when a turn command is auto-cancelled.

Behaviour:
- Reset (rst=0): all registers clear immediately. Outputs l=r=h=0, mode=00, timeout_flag=0. Sync flops, debounced values and counters are all 0. FSM goes to IDLE.
- Synchronizer: 2 flops per raw input.
- Debounce, per channel:
  - Track a debounced value db and a counter cnt.
  - If sync==db: cnt<=0.
  - Else if cnt==DEBOUNCE_CYC-1: db<=sync and cnt<=0.
  - Else: cnt++.
  - Any bounce back to db restarts the count.
- Request resolution (combinational from db values):
  - db_h=1 -> HAZ (hazard has top priority).
  - Else db_l=1 and db_r=1 -> NONE (conflict).
  - Else db_l -> LEFT; else db_r -> RIGHT; else NONE.
- FSM states: IDLE, LEFT, RIGHT, HAZARD, GAP, LOCK. Moore outputs decoded from state:
  - IDLE/GAP/LOCK: l=r=h=0.
  - LEFT: l=1, mode 10.
  - RIGHT: r=1, mode 01.
  - HAZARD: h=1, mode 11.
- Transitions:
  - IDLE -> state matching the request, or stay in IDLE if the request is NONE.
  - Active state with request NONE -> IDLE.
  - Active state with a different non-NONE request -> GAP for exactly 1 cycle, then to the state matching the request at that time (IDLE if NONE).
  - LEFT/RIGHT: a dwell counter clears on entry and increments each cycle. With TIMEOUT_CYC>0 and the state held TIMEOUT_CYC cycles -> LOCK.
    - Record lock_dir (L or R) on entry to LOCK.
    - Pulse timeout_flag in the first LOCK cycle.
  - LOCK -> IDLE when the request differs from lock_dir, including NONE. A HAZ request passes through IDLE, so hazard is delayed one cycle.
  - HAZARD never times out.
- Latency: a raw edge stable from before clock edge 1 shows on the outputs after 3+DEBOUNCE_CYC edges (7 with defaults): 2 sync + DEBOUNCE_CYC debounce + 1 FSM.
- Counter widths are $clog2(param)+1. Counters saturate and never wrap.
- Exactly one of l/r/h is high at a time, or none; never two.
- Asserting reset mid-command drops outputs the same cycle. After release, inputs must pass the full sync+debounce latency again.

Decomposition:
- Package turn_pkg:
  - mode_t enum {Z=2'b00, R=2'b01, L=2'b10, H=2'b11}, shared with the sequencer.
  - ctrl_state_t enum {IDLE, LEFT, RIGHT, HAZARD, GAP, LOCK}.
  - req_t enum {NONE, REQ_L, REQ_R, REQ_H}.
- Sub-module switch_debounce: 2-flop sync plus debounce for one bit, parameter DEBOUNCE_CYC, ports clk_out, rst, raw, db. Instantiated 3 times.

Test Plan:
1. Reset: hold rst=0 with all raw inputs at 1 -> l=r=h=0, mode=00, timeout_flag=0 throughout; no output change until 7 edges after rst rises.
2. Debounce: l_raw 0->1 held -> l=1, mode=10 exactly 7 edges later. Then l_raw toggling every 2 cycles for 12 cycles from idle -> l stays 0.
3. Preemption: LEFT active, then h_raw=1 -> after debounce, one cycle mode=00, then mode=11, h=1, l=0. Drop h_raw with l_raw still 1 -> GAP 1 cycle, then mode=10.
4. Conflict: l_raw=r_raw=1, h_raw=0 -> mode stays 00. Release r_raw -> mode=10 after 7 edges.
5. Timeout: r_raw held 100 cycles -> r=1 for exactly 64 cycles, then r=0 and timeout_flag=1 for 1 cycle; mode 00 while r_raw stays 1. Release, wait 10, re-press -> r=1 after 7 edges.
6. Reset mid-HAZARD with h_raw held 1 -> h=0 immediately on rst=0; after rst=1, h=1 after 7 edges.
